io_break_arb: RTL and testbench



---
 rtl/pdp8_pkg.sv | 14 +
 rtl/break_pick.sv | 28 ++
 rtl/io_break_arb.sv | 109 ++++++++++
 tb/tb_io_break_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared constants for the PDP-8/e break (DMA) logic: FSM encoding,
// default address/data widths and the grant index width.
package pdp8_pkg;

    localparam int AW_DEF = 15;
    localparam int DW_DEF = 12;
    localparam int GID_W  = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

endpackage

// File: rtl/break_pick.sv
// Combinational winner selection for the break arbiter: scans the request
// vector starting at ptr and wrapping modulo NCH; first set bit wins.
module break_pick
    import pdp8_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]   req,
    input  logic [GID_W-1:0] ptr,
    output logic             valid,
    output logic [GID_W-1:0] idx
);

    always_comb begin
        int unsigned c;
        c     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            c = (32'(ptr) + i) % NCH;
            if (!valid && (|(req & (NCH'(1) << c)))) begin
                valid = 1'b1;
                idx   = GID_W'(c);
            end
        end
    end

endmodule

// File: rtl/io_break_arb.sv
// N-channel data-break arbiter feeding the PDP-8/e MA datapath.
// Define ROUND_ROBIN_EN for rotating priority; otherwise channel 0 is highest.
module io_break_arb
    import pdp8_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_to_mem,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wdata,
    output logic [NCH-1:0]    ch_ack,
    output logic [DW-1:0]     ch_rdata,
    output logic              data_break,
    output logic              to_dev,
    output logic [AW-1:0]     dmaAddr,
    output logic [DW-1:0]     dmaDOUT,
    input  logic [DW-1:0]     dmaDIN,
    input  logic              break_in_prog,
    output logic [GID_W-1:0]  grant_id
);

    logic [1:0]       state;
    logic [GID_W-1:0] ptr;
    logic             pick_valid;
    logic [GID_W-1:0] pick_idx;
    logic [NCH-1:0]   pick_oh;
    logic [NCH-1:0]   grant_oh;
    logic [AW-1:0]    pick_addr;
    logic [DW-1:0]    pick_wdata;

    break_pick #(.NCH(NCH)) u_pick (
        .req   (ch_req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_oh    = NCH'(1) << pick_idx;
    assign grant_oh   = NCH'(1) << grant_id;
    assign pick_addr  = AW'(ch_addr >> (pick_idx * AW));
    assign pick_wdata = DW'(ch_wdata >> (pick_idx * DW));

`ifdef ROUND_ROBIN_EN
    // Last winner drops to lowest priority once its cycle is acknowledged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (state == ST_ACK) begin
            ptr <= (grant_id == GID_W'(NCH - 1)) ? '0 : grant_id + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            data_break <= 1'b0;
            to_dev     <= 1'b0;
            ch_ack     <= '0;
            ch_rdata   <= '0;
            dmaAddr    <= '0;
            dmaDOUT    <= '0;
            grant_id   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid && !clear) begin
                        grant_id   <= pick_idx;
                        dmaAddr    <= pick_addr;
                        dmaDOUT    <= pick_wdata;
                        to_dev     <= ~(|(ch_to_mem & pick_oh));
                        data_break <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A cycle already started by the state machine wins over clear.
                    if (break_in_prog) begin
                        state <= ST_BUSY;
                    end else if (!(|(ch_req & grant_oh)) || clear) begin
                        data_break <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!break_in_prog) begin
                        ch_rdata   <= dmaDIN;
                        data_break <= 1'b0;
                        ch_ack     <= grant_oh;
                        state      <= ST_ACK;
                    end
                end
                default: begin
                    ch_ack <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_break_arb.sv
// Self-checking bench for io_break_arb (NCH=4) with a randomized requester
// population and a priority model; honours ROUND_ROBIN_EN like the design.
module tb_io_break_arb;

    localparam int NCH = 4;
    localparam int AW  = 15;
    localparam int DW  = 12;

    logic              clk = 1'b0;
    logic              resetn;
    logic              clear;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_to_mem;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [NCH-1:0]    ch_ack;
    logic [DW-1:0]     ch_rdata;
    logic              data_break;
    logic              to_dev;
    logic [AW-1:0]     dmaAddr;
    logic [DW-1:0]     dmaDOUT;
    logic [DW-1:0]     dmaDIN;
    logic              break_in_prog;
    logic [2:0]        grant_id;

    io_break_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .clear         (clear),
        .ch_req        (ch_req),
        .ch_to_mem     (ch_to_mem),
        .ch_addr       (ch_addr),
        .ch_wdata      (ch_wdata),
        .ch_ack        (ch_ack),
        .ch_rdata      (ch_rdata),
        .data_break    (data_break),
        .to_dev        (to_dev),
        .dmaAddr       (dmaAddr),
        .dmaDOUT       (dmaDOUT),
        .dmaDIN        (dmaDIN),
        .break_in_prog (break_in_prog),
        .grant_id      (grant_id)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rr_ptr = 0;

    logic [AW-1:0] a_tab [NCH];
    logic [DW-1:0] w_tab [NCH];

    // Reference priority: first requesting channel at or after rr_ptr, wrapping.
    function automatic int exp_winner(input logic [NCH-1:0] req);
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (rr_ptr + i) % NCH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_ack(input int w);
`ifdef ROUND_ROBIN_EN
        rr_ptr = (w + 1) % NCH;
`else
        rr_ptr = 0;
`endif
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pack_inputs;
        for (int i = 0; i < NCH; i++) begin
            ch_addr[i*AW +: AW]  = a_tab[i];
            ch_wdata[i*DW +: DW] = w_tab[i];
        end
    endtask

    task automatic random_tabs;
        for (int i = 0; i < NCH; i++) begin
            a_tab[i] = AW'($urandom);
            w_tab[i] = DW'($urandom);
        end
        ch_to_mem = NCH'($urandom);
        pack_inputs();
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        rr_ptr = 0;
        step();
    endtask

    task automatic test_reset;
        resetn = 1'b0; clear = 1'b0; ch_req = '0; ch_to_mem = '0;
        ch_addr = '0; ch_wdata = '0; dmaDIN = '0; break_in_prog = 1'b0;
        step(); step();
        tests++; if (data_break !== 1'b0) begin fails++; $display("FAIL reset_db: got %b want 0", data_break); end
        tests++; if (to_dev !== 1'b0) begin fails++; $display("FAIL reset_to_dev: got %b want 0", to_dev); end
        tests++; if (ch_ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b want 0000", ch_ack); end
        tests++; if (ch_rdata !== 12'o0) begin fails++; $display("FAIL reset_rdata: got %o want 0", ch_rdata); end
        tests++; if (dmaAddr !== 15'o0) begin fails++; $display("FAIL reset_addr: got %o want 0", dmaAddr); end
        tests++; if (dmaDOUT !== 12'o0) begin fails++; $display("FAIL reset_dout: got %o want 0", dmaDOUT); end
        tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
        resetn = 1'b1;
        rr_ptr = 0;
        step();
    endtask

    task automatic test_single;
        for (int i = 0; i < NCH; i++) begin a_tab[i] = '0; w_tab[i] = '0; end
        a_tab[2] = 15'o10200;
        ch_to_mem = 4'b0000;
        pack_inputs();
        ch_req = 4'b0100;
        step();
        tests++; if (data_break !== 1'b1) begin fails++; $display("FAIL single_db: got %b want 1", data_break); end
        tests++; if (dmaAddr !== 15'o10200) begin fails++; $display("FAIL single_addr: got %o want 10200", dmaAddr); end
        tests++; if (to_dev !== 1'b1) begin fails++; $display("FAIL single_to_dev: got %b want 1", to_dev); end
        tests++; if (grant_id !== 3'd2) begin fails++; $display("FAIL single_gid: got %0d want 2", grant_id); end
        step(); step();
        break_in_prog = 1'b1;
        dmaDIN = 12'o5252;
        step(); step(); step();
        tests++; if (data_break !== 1'b1) begin fails++; $display("FAIL single_busy_db: got %b want 1", data_break); end
        tests++; if (ch_ack !== 4'b0000) begin fails++; $display("FAIL single_early_ack: got %b want 0000", ch_ack); end
        break_in_prog = 1'b0;
        step();
        tests++; if (ch_ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b want 0100", ch_ack); end
        tests++; if (ch_rdata !== 12'o5252) begin fails++; $display("FAIL single_rdata: got %o want 5252", ch_rdata); end
        tests++; if (data_break !== 1'b0) begin fails++; $display("FAIL single_ack_db: got %b want 0", data_break); end
        tests++; if (dmaAddr !== 15'o10200) begin fails++; $display("FAIL single_addr_hold: got %o want 10200", dmaAddr); end
        ch_req = 4'b0000;
        model_ack(2);
        step();
        tests++; if (ch_ack !== 4'b0000) begin fails++; $display("FAIL single_ack_pulse: got %b want 0000", ch_ack); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 24; it++) begin
            logic [NCH-1:0] req;
            logic [NCH-1:0] oh;
            logic [DW-1:0]  din;
            int             w;
            int             d;
            req = NCH'($urandom_range(1, (1 << NCH) - 1));
            random_tabs();
            w  = exp_winner(req);
            oh = NCH'(1) << w;
            ch_req = req;
            step();
            tests++; if (data_break !== 1'b1) begin fails++; $display("FAIL rand_db it=%0d: got %b want 1", it, data_break); end
            tests++; if (grant_id !== 3'(w)) begin fails++; $display("FAIL rand_gid it=%0d req=%b: got %0d want %0d", it, req, grant_id, w); end
            tests++; if (dmaAddr !== a_tab[w]) begin fails++; $display("FAIL rand_addr it=%0d: got %o want %o", it, dmaAddr, a_tab[w]); end
            tests++; if (dmaDOUT !== w_tab[w]) begin fails++; $display("FAIL rand_dout it=%0d: got %o want %o", it, dmaDOUT, w_tab[w]); end
            tests++; if (to_dev !== !ch_to_mem[w]) begin fails++; $display("FAIL rand_to_dev it=%0d: got %b want %b", it, to_dev, !ch_to_mem[w]); end
            d = $urandom_range(0, 2);
            for (int k = 0; k < d; k++) step();
            break_in_prog = 1'b1;
            d = $urandom_range(1, 3);
            for (int k = 0; k < d; k++) step();
            tests++; if (data_break !== 1'b1 || ch_ack !== '0) begin fails++; $display("FAIL rand_busy it=%0d: got db=%b ack=%b want db=1 ack=0000", it, data_break, ch_ack); end
            din = DW'($urandom);
            dmaDIN = din;
            break_in_prog = 1'b0;
            step();
            tests++; if (ch_ack !== oh) begin fails++; $display("FAIL rand_ack it=%0d: got %b want %b", it, ch_ack, oh); end
            tests++; if (ch_rdata !== din) begin fails++; $display("FAIL rand_rdata it=%0d: got %o want %o", it, ch_rdata, din); end
            tests++; if (dmaAddr !== a_tab[w] || data_break !== 1'b0) begin fails++; $display("FAIL rand_ack_state it=%0d: got addr=%o db=%b want addr=%o db=0", it, dmaAddr, data_break, a_tab[w]); end
            ch_req[w] = 1'b0;
            model_ack(w);
            step();
            tests++; if (ch_ack !== '0 || data_break !== 1'b0) begin fails++; $display("FAIL rand_idle it=%0d: got ack=%b db=%b want 0000/0", it, ch_ack, data_break); end
        end
        ch_req = '0;
        step();
    endtask

    task automatic test_contention;
        int exp_order [5];
`ifdef ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        do_reset();
        random_tabs();
        ch_req = '1;
        for (int k = 0; k < 5; k++) begin
            logic [NCH-1:0] oh;
            int w;
            w = exp_winner(ch_req);
            step();
            tests++; if (grant_id !== 3'(exp_order[k]) || w != exp_order[k]) begin fails++; $display("FAIL cont_order k=%0d: got %0d model %0d want %0d", k, grant_id, w, exp_order[k]); end
            tests++; if (dmaAddr !== a_tab[exp_order[k]]) begin fails++; $display("FAIL cont_addr k=%0d: got %o want %o", k, dmaAddr, a_tab[exp_order[k]]); end
            break_in_prog = 1'b1;
            step();
            break_in_prog = 1'b0;
            dmaDIN = DW'($urandom);
            step();
            oh = NCH'(1) << exp_order[k];
            tests++; if (ch_ack !== oh) begin fails++; $display("FAIL cont_ack k=%0d: got %b want %b", k, ch_ack, oh); end
            model_ack(exp_order[k]);
            step();
        end
        // Channel 0 leaves: the next winner follows the reference priority.
        ch_req = 4'b1110;
        begin
            int w;
            w = exp_winner(ch_req);
            step();
            tests++; if (grant_id !== 3'(w)) begin fails++; $display("FAIL cont_drop0: got %0d want %0d", grant_id, w); end
            ch_req = '0;
            step();
            step();
        end
    endtask

    task automatic test_abandon;
        do_reset();
        random_tabs();
        ch_req = 4'b0010;
        step();
        tests++; if (data_break !== 1'b1 || grant_id !== 3'd1) begin fails++; $display("FAIL abandon_grant: got db=%b gid=%0d want 1/1", data_break, grant_id); end
        ch_req = 4'b0000;
        step();
        tests++; if (data_break !== 1'b0) begin fails++; $display("FAIL abandon_db: got %b want 0", data_break); end
        step();
        tests++; if (ch_ack !== '0 || data_break !== 1'b0) begin fails++; $display("FAIL abandon_noack: got ack=%b db=%b want 0000/0", ch_ack, data_break); end
        ch_req = 4'b0100;
        step();
        clear = 1'b1;
        step();
        tests++; if (data_break !== 1'b0) begin fails++; $display("FAIL clear_req_db: got %b want 0", data_break); end
        step();
        tests++; if (data_break !== 1'b0 || ch_ack !== '0) begin fails++; $display("FAIL clear_idle: got db=%b ack=%b want 0/0000", data_break, ch_ack); end
        clear = 1'b0;
        ch_req = '0;
        step();
    endtask

    task automatic test_clear_busy;
        random_tabs();
        ch_req = 4'b0001;
        step();
        break_in_prog = 1'b1;
        step();
        clear = 1'b1;
        step();
        tests++; if (data_break !== 1'b1) begin fails++; $display("FAIL clear_busy_db: got %b want 1", data_break); end
        break_in_prog = 1'b0;
        dmaDIN = 12'o1234;
        step();
        tests++; if (ch_ack !== 4'b0001 || ch_rdata !== 12'o1234) begin fails++; $display("FAIL clear_busy_ack: got ack=%b rdata=%o want 0001/1234", ch_ack, ch_rdata); end
        model_ack(0);
        ch_req = '0;
        clear = 1'b0;
        step();
        ch_req = 4'b1000;
        step();
        clear = 1'b1;
        break_in_prog = 1'b1;
        step();
        tests++; if (data_break !== 1'b1) begin fails++; $display("FAIL clear_bip_race: got db=%b want 1", data_break); end
        clear = 1'b0;
        break_in_prog = 1'b0;
        step();
        tests++; if (ch_ack !== 4'b1000) begin fails++; $display("FAIL clear_race_ack: got %b want 1000", ch_ack); end
        model_ack(3);
        ch_req = '0;
        step();
    endtask

    task automatic test_reset_busy;
        random_tabs();
        ch_req = 4'b0001;
        step();
        break_in_prog = 1'b1;
        step();
        #2;
        resetn = 1'b0;
        #1;
        tests++; if (data_break !== 1'b0 || to_dev !== 1'b0 || ch_ack !== '0) begin fails++; $display("FAIL rst_busy_ctl: got db=%b to_dev=%b ack=%b want 0/0/0000", data_break, to_dev, ch_ack); end
        tests++; if (dmaAddr !== '0 || dmaDOUT !== '0 || ch_rdata !== '0 || grant_id !== '0) begin fails++; $display("FAIL rst_busy_data: got addr=%o dout=%o rdata=%o gid=%0d want 0", dmaAddr, dmaDOUT, ch_rdata, grant_id); end
        break_in_prog = 1'b0;
        ch_req = '0;
        step();
        resetn = 1'b1;
        rr_ptr = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            tests++; if (ch_ack !== '0 || data_break !== 1'b0) begin fails++; $display("FAIL rst_busy_after k=%0d: got ack=%b db=%b want 0000/0", k, ch_ack, data_break); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_contention();
        test_abandon();
        test_clear_busy();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
